design_31: RTL and testbench

//   Single-cycle registered adder with start/valid handshake. A start pulse captures
//   a+b into the output register. valid asserts exactly one clock later.

---
 rtl/design_31_pkg.sv | 36 +++
 rtl/design_31_adder.sv | 38 +++
 rtl/design_31.sv | 63 ++++++
 tb/tb_design_31.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/design_31_pkg.sv
`default_nettype none
// ============================================================================
// Module   : design_31_pkg
// Purpose  : Shared constants and the width-generic add helper for design_31.
//            Build option DESIGN_31_SAT_EN (saturating sum) is consumed by
//            design_31_adder; this package is identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
package design_31_pkg;

  localparam int unsigned W_DEFAULT = 10;

  // Widest operand the helper supports; the carry lands in bit ADD_MAX_W.
  localparam int unsigned ADD_MAX_W = 64;

  // Returns {carry, sum}. The sum is truncated to 'width' bits and the carry
  // is bit 'width' of the full-precision add. Operands must already fit in
  // 'width' bits (1 <= width <= ADD_MAX_W).
  function automatic logic [ADD_MAX_W:0] add_w(
    input logic [ADD_MAX_W-1:0] a,
    input logic [ADD_MAX_W-1:0] b,
    input int unsigned          width
  );
    logic [ADD_MAX_W:0] full;
    logic [ADD_MAX_W:0] res;
    full = {1'b0, a} + {1'b0, b};
    res  = '0;
    for (int i = 0; i < ADD_MAX_W; i++) begin
      if (i < int'(width)) res[i] = full[i];
    end
    res[ADD_MAX_W] = full[width[6:0]];
    return res;
  endfunction

endpackage : design_31_pkg
`default_nettype wire

// File: rtl/design_31_adder.sv
`default_nettype none
// ============================================================================
// Module   : design_31_adder
// Purpose  : Combinational W-bit unsigned add with carry-out. The result
//            wraps modulo 2^W by default; with DESIGN_31_SAT_EN defined it
//            clamps to all-ones on carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module design_31_adder
  import design_31_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  logic [ADD_MAX_W:0] w_full;
  logic [W-1:0]       w_sum;
  logic               w_carry;
  logic               w_unused;

  assign w_full  = add_w(ADD_MAX_W'(a_i), ADD_MAX_W'(b_i), W);
  assign w_sum   = w_full[W-1:0];
  assign w_carry = w_full[ADD_MAX_W];

  // Bits above W are always zero and carry is unused in the wrap build.
  assign w_unused = ^{w_full, w_carry};

`ifdef DESIGN_31_SAT_EN
  assign sum_o = w_carry ? {W{1'b1}} : w_sum;
`else
  assign sum_o = w_sum;
`endif

endmodule : design_31_adder
`default_nettype wire

// File: rtl/design_31.sv
`default_nettype none
// ============================================================================
// Module   : design_31
// Purpose  : Single-cycle registered adder with start/valid handshake.
//            A start strobe captures a+b into y; valid pulses one cycle later.
//            Build option DESIGN_31_SAT_EN selects saturating instead of
//            wrap-around arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module design_31
  import design_31_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         valid
);

  logic [W-1:0] w_sum;
  logic [W-1:0] y_d;
  logic [W-1:0] y_q;
  logic         valid_d;
  logic         valid_q;

  design_31_adder #(
    .W (W)
  ) u_adder (
    .a_i   (a),
    .b_i   (b),
    .sum_o (w_sum)
  );

  // Next state: capture the sum on start, otherwise hold y and drop valid.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (start) begin
      y_d     = w_sum;
      valid_d = 1'b1;
    end
  end

  // Output registers; reset clears both immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

endmodule : design_31
`default_nettype wire

// File: tb/tb_design_31.sv
`default_nettype none
// ============================================================================
// Module   : tb_design_31
// Purpose  : Self-checking bench for design_31 (W=10). Expectations come from
//            an arithmetic reference model; DESIGN_31_SAT_EN selects the
//            saturating expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_design_31;

  localparam int W    = 10;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;

  int n_cmp;
  int n_err;
  int exp_y;
  int exp_valid;
  int pulses;
  int starts;

  design_31 #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .y     (y),
    .valid (valid)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute run bound.
  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time bound");
    $fatal(1, "timeout");
  end

  // Reference sum from the arithmetic rule, not the RTL structure.
  function automatic int ref_sum(input int x, input int z);
    int s;
    s = x + z;
`ifdef DESIGN_31_SAT_EN
    if (s > MAXV) s = MAXV;
`else
    s = s % (MAXV + 1);
`endif
    return s;
  endfunction

  task automatic check(input string tag);
    n_cmp++;
    assert (int'(valid) === exp_valid) else begin
      n_err++;
      $error("FAIL %s.valid observed=%0d expected=%0d", tag, valid, exp_valid);
    end
    n_cmp++;
    assert (int'(y) === exp_y) else begin
      n_err++;
      $error("FAIL %s.y observed=%0d expected=%0d", tag, y, exp_y);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 later.
  task automatic cycle(input logic s, input int aa, input int bb, input string tag);
    start = s;
    a     = W'(aa);
    b     = W'(bb);
    @(posedge clk);
    if (!rst_n) begin
      exp_y     = 0;
      exp_valid = 0;
    end else if (s) begin
      exp_y     = ref_sum(aa, bb);
      exp_valid = 1;
    end else begin
      exp_valid = 0;
    end
    #1;
    check(tag);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pulses = 0; starts = 0;
    exp_y = 0; exp_valid = 0;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1 check("reset_async");

    // Reset held 3 cycles with start high: must be ignored.
    for (int i = 0; i < 3; i++) cycle(1'b1, 500, 400, "start_in_reset");
    rst_n = 1'b1;

    // Scenario 1: basic capture and hold.
    cycle(1'b1, 3, 5, "basic_capture");
    cycle(1'b0, 0, 0, "basic_hold");
    cycle(1'b0, 77, 88, "basic_hold2");

    // Scenario 2: overflow boundary, plus the largest non-overflowing sum.
    cycle(1'b1, MAXV, 1, "overflow");
    cycle(1'b1, MAXV, MAXV, "overflow_max");
    cycle(1'b1, 1000, 23, "no_overflow_edge");
    cycle(1'b0, 0, 0, "overflow_idle");

    // Scenario 3: back-to-back starts.
    cycle(1'b1, 1, 2, "b2b_0");
    cycle(1'b1, 10, 20, "b2b_1");
    cycle(1'b1, 100, 200, "b2b_2");
    cycle(1'b0, 0, 0, "b2b_end");

    // Scenario 4: random one-shot starts with idle gaps; count pulses.
    for (int i = 0; i < 10; i++) begin
      int ra, rb;
      ra = int'($urandom_range(MAXV, 0));
      rb = int'($urandom_range(MAXV, 0));
      starts++;
      cycle(1'b1, ra, rb, "rand_start");
      if (valid === 1'b1) pulses++;
      cycle(1'b0, int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)), "rand_idle0");
      if (valid === 1'b1) pulses++;
      cycle(1'b0, int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)), "rand_idle1");
      if (valid === 1'b1) pulses++;
    end
    n_cmp++;
    assert (pulses === starts) else begin
      n_err++;
      $error("FAIL rand_pulse_count observed=%0d expected=%0d", pulses, starts);
    end

    // Scenario 5: reset between edges right after a capture.
    cycle(1'b1, 7, 9, "midop_capture");
    #2 rst_n = 1'b0;
    exp_y = 0; exp_valid = 0;
    #1 check("midop_async_clear");
    // Scenario 6: start during reset is ignored.
    cycle(1'b1, 300, 300, "midop_start_in_reset0");
    cycle(1'b1, 12, 34, "midop_start_in_reset1");
    rst_n = 1'b1;
    cycle(1'b0, 7, 9, "post_reset_idle0");
    cycle(1'b0, 7, 9, "post_reset_idle1");
    cycle(1'b1, 40, 2, "post_reset_capture");
    cycle(1'b0, 0, 0, "post_reset_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_design_31
`default_nettype wire
